// File: rtl/sfp_norm.sv
// sfp_norm: special-function normalize stage.
// Sums |psum| per row, swaps sums with the partner core, divides per element.
module sfp_norm #(
  parameter int col     = 8,
  parameter int bw_psum = 24,
  parameter int FRAC    = 8,
  parameter int bw_sum  = bw_psum + $clog2(col)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                sfp_op,
  input  logic                      in_valid,
  input  logic [col*bw_psum-1:0]    in_data,
  input  logic                      int_fifo_full,
  output logic [bw_sum-1:0]         sum_out,
  output logic                      sum_out_wr,
  input  logic [bw_sum-1:0]         sum_in,
  input  logic                      sum_in_valid,
  output logic                      sum_in_rd,
  output logic [col*(FRAC+1)-1:0]   out_data,
  output logic                      out_valid,
  output logic                      sfp_ready
);

  localparam int BW_ELEM = $clog2(col);
  localparam int BW_BIT  = $clog2(FRAC + 1);
  localparam int BW_TOT  = bw_sum + 1;
  localparam int BW_REM  = bw_sum + 2;
  localparam logic [BW_ELEM-1:0] ELEM_LAST = BW_ELEM'(col - 1);
  localparam logic [BW_BIT-1:0]  BIT_LAST  = BW_BIT'(FRAC);

  localparam logic [1:0] OP_ACCUM = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_PUSH,
    S_WAIT,
    S_ARMED,
    S_DIV,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [col*bw_psum-1:0]    in_reg_q;
  logic [bw_sum-1:0]         local_sum_q;
  logic [BW_TOT-1:0]         total_q;
  logic [col*(FRAC+1)-1:0]   out_q;
  logic [BW_ELEM-1:0]        elem_q;
  logic [BW_BIT-1:0]         bit_q;
  logic [BW_REM-1:0]         rem_q;
  logic [FRAC:0]             quo_q;

  logic [bw_psum-1:0]        abs_v [col];
  logic [bw_sum-1:0]         sum_d;
  logic [BW_ELEM-1:0]        nxt_elem;
  logic                      ge;
  logic [BW_REM-1:0]         tot_ext;
  logic [BW_REM-1:0]         rem_step;
  logic [FRAC:0]             quo_step;

  // Per-element magnitude and the row's local absolute sum.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < col; i++) begin
      logic [bw_psum-1:0] e;
      e = in_reg_q[i*bw_psum +: bw_psum];
      abs_v[i] = e[bw_psum-1] ? (~e + 1'b1) : e;
      sum_d = sum_d + bw_sum'(abs_v[i]);
    end
  end

  // One restoring-division step on the current element.
  always_comb begin
    nxt_elem = elem_q + 1'b1;
    tot_ext  = BW_REM'(total_q);
    ge       = (rem_q >= tot_ext);
    quo_step = {quo_q[FRAC-1:0], ge};
    rem_step = (ge ? (rem_q - tot_ext) : rem_q) << 1;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (sfp_op == OP_ACCUM && in_valid)
          state_d = S_SUM;
      S_SUM:
        state_d = S_PUSH;
      S_PUSH:
        if (!int_fifo_full)
          state_d = S_WAIT;
      S_WAIT:
        if (sum_in_valid)
          state_d = S_ARMED;
      S_ARMED:
        if (sfp_op == OP_DIV)
          state_d = (total_q == '0) ? S_DONE : S_DIV;
      S_DIV:
        if (bit_q == BIT_LAST && elem_q == ELEM_LAST)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers: input latch, sums, divider, results.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_reg_q    <= '0;
      local_sum_q <= '0;
      total_q     <= '0;
      out_q       <= '0;
      elem_q      <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (sfp_op == OP_ACCUM && in_valid)
            in_reg_q <= in_data;
        S_SUM:
          local_sum_q <= sum_d;
        S_WAIT:
          if (sum_in_valid)
            total_q <= BW_TOT'(local_sum_q) + BW_TOT'(sum_in);
        S_ARMED:
          if (sfp_op == OP_DIV) begin
            if (total_q == '0) out_q <= '0;
            elem_q <= '0;
            bit_q  <= '0;
            quo_q  <= '0;
            rem_q  <= BW_REM'(abs_v[0]);
          end
        S_DIV:
          if (bit_q == BIT_LAST) begin
            out_q[elem_q*(FRAC+1) +: (FRAC+1)] <= quo_step;
            bit_q  <= '0;
            quo_q  <= '0;
            elem_q <= nxt_elem;
            rem_q  <= BW_REM'(abs_v[nxt_elem]);
          end else begin
            bit_q <= bit_q + 1'b1;
            quo_q <= quo_step;
            rem_q <= rem_step;
          end
        default: ;
      endcase
    end
  end

  assign sum_out    = local_sum_q;
  assign sum_out_wr = (state_q == S_PUSH) && !int_fifo_full;
  assign sum_in_rd  = (state_q == S_WAIT) && sum_in_valid;
  assign out_data   = out_q;
  assign out_valid  = (state_q == S_DONE);
  assign sfp_ready  = (state_q == S_IDLE);

endmodule

// File: tb/tb_sfp_norm.sv
// tb_sfp_norm: directed vectors for the normalize stage.
// Drives and samples on the falling edge.
module tb_sfp_norm;

  localparam int COL = 8;
  localparam int BWP = 24;
  localparam int FR  = 8;
  localparam int BWS = 27;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             sfp_op;
  logic                   in_valid;
  logic [COL*BWP-1:0]     in_data;
  logic                   int_fifo_full;
  logic [BWS-1:0]         sum_out;
  logic                   sum_out_wr;
  logic [BWS-1:0]         sum_in;
  logic                   sum_in_valid;
  logic                   sum_in_rd;
  logic [COL*(FR+1)-1:0]  out_data;
  logic                   out_valid;
  logic                   sfp_ready;

  always #5 clk = ~clk;

  sfp_norm #(
    .col(COL), .bw_psum(BWP), .FRAC(FR), .bw_sum(BWS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sfp_op(sfp_op),
    .in_valid(in_valid),
    .in_data(in_data),
    .int_fifo_full(int_fifo_full),
    .sum_out(sum_out),
    .sum_out_wr(sum_out_wr),
    .sum_in(sum_in),
    .sum_in_valid(sum_in_valid),
    .sum_in_rd(sum_in_rd),
    .out_data(out_data),
    .out_valid(out_valid),
    .sfp_ready(sfp_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic signed [BWP-1:0] ps [COL];
  logic [FR:0]           ex [COL];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".ready"}, sfp_ready, 1);
    chk({tag, ".ovld"}, out_valid, 0);
    chk({tag, ".wr"}, sum_out_wr, 0);
    chk({tag, ".rd"}, sum_in_rd, 0);
    chk({tag, ".out"}, out_data, 0);
    chk({tag, ".sum"}, sum_out, 0);
  endtask

  // One full ACCUM/push/pop/DIV transaction using ps[] and ex[].
  task automatic run(input string nm,
                     input logic [BWS-1:0] partner,
                     input logic [BWS-1:0] xsum,
                     input int full_cyc,
                     input int wait_cyc,
                     input bit zero,
                     input int abort_at);
    logic [COL*BWP-1:0]    d;
    logic [COL*(FR+1)-1:0] xo;
    int cnt;
    for (int i = 0; i < COL; i++) begin
      d[i*BWP +: BWP]   = ps[i];
      xo[i*(FR+1) +: FR+1] = ex[i];
    end
    @(negedge clk);
    sfp_op = 2'b01; in_valid = 1'b1; in_data = d;
    @(negedge clk);
    sfp_op = 2'b00; in_valid = 1'b0; in_data = '0;
    chk({nm, ".busy"}, sfp_ready, 0);
    int_fifo_full = (full_cyc > 0);
    @(negedge clk);
    for (int k = 0; k < full_cyc; k++) begin
      chk({nm, ".stall_wr"}, sum_out_wr, 0);
      @(negedge clk);
    end
    int_fifo_full = 1'b0;
    #1;
    chk({nm, ".wr"}, sum_out_wr, 1);
    chk({nm, ".sum"}, sum_out, xsum);
    @(negedge clk);
    chk({nm, ".wr_once"}, sum_out_wr, 0);
    for (int k = 0; k < wait_cyc; k++) begin
      sfp_op = 2'b11;
      #1;
      chk({nm, ".no_pop"}, sum_in_rd, 0);
      chk({nm, ".wait_busy"}, sfp_ready, 0);
      @(negedge clk);
    end
    sfp_op = 2'b00;
    sum_in = partner; sum_in_valid = 1'b1;
    #1;
    chk({nm, ".pop"}, sum_in_rd, 1);
    @(negedge clk);
    sum_in_valid = 1'b0; sum_in = '0;
    @(negedge clk);
    chk({nm, ".armed"}, out_valid, 0);
    sfp_op = 2'b11;
    @(negedge clk);
    sfp_op = 2'b00;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_rst({nm, ".rst"});
      reset = 1'b0;
      return;
    end
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, ".lat"}, cnt, zero ? 0 : 72);
    chk({nm, ".out"}, out_data, xo);
    @(negedge clk);
    chk({nm, ".ovld_1cyc"}, out_valid, 0);
    chk({nm, ".idle"}, sfp_ready, 1);
  endtask

  task automatic fill(input logic signed [BWP-1:0] v, input logic [FR:0] e);
    for (int i = 0; i < COL; i++) begin
      ps[i] = v;
      ex[i] = e;
    end
  endtask

  initial begin
    reset = 1'b1; sfp_op = '0; in_valid = 1'b0; in_data = '0;
    int_fifo_full = 1'b0; sum_in = '0; sum_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_rst("reset");
    reset = 1'b0;

    fill(24'sd16, 9'd16);
    run("basic", 27'd128, 27'd128, 0, 0, 1'b0, 0);

    fill(24'sd16, 9'd16);
    for (int i = 0; i < COL; i += 2) ps[i] = -24'sd16;
    run("signed", 27'd128, 27'd128, 0, 0, 1'b0, 0);

    fill(24'sd0, 9'd0);
    ps[0] = 24'sd100; ex[0] = 9'h100;
    run("sat", 27'd0, 27'd100, 0, 0, 1'b0, 0);

    fill(24'sd0, 9'd0);
    ps[0] = 24'sh800000; ex[0] = 9'h100;
    run("mostneg", 27'd0, 27'd8388608, 0, 0, 1'b0, 0);

    fill(24'sd0, 9'd0);
    ps[0] = 24'sd1;  ex[0] = 9'd25;
    ps[1] = -24'sd2; ex[1] = 9'd51;
    ps[2] = 24'sd3;  ex[2] = 9'd76;
    run("floor", 27'd4, 27'd6, 0, 0, 1'b0, 0);

    fill(24'sd0, 9'd0);
    run("zero", 27'd0, 27'd0, 0, 0, 1'b1, 0);

    fill(24'sd16, 9'd16);
    run("bkpr", 27'd128, 27'd128, 5, 4, 1'b0, 0);

    fill(24'sd16, 9'd16);
    run("abort", 27'd128, 27'd128, 0, 0, 1'b0, 30);

    fill(24'sd16, 9'd16);
    run("after", 27'd128, 27'd128, 0, 0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_norm.md
Name: sfp_norm

Overview:
- Special-function stage downstream of the core controller.
- Takes one row of col partial sums from the ofifo and computes its local absolute sum.
- Exchanges that sum with the partner core through an inter-core FIFO.
- Normalizes each element against the combined sum: out_i = floor(|psum_i| * 2^FRAC / total).
- Driven by the controller's 2-bit SFP opcode. Returns sfp_ready to the controller and honours int_fifo_full.

Parameters:
- col, 8: psum elements per row.
- bw_psum, 24: signed psum width.
- FRAC, 8: fractional bits of each normalized output.
- bw_sum, bw_psum+$clog2(col): local-sum width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- sfp_op  in  2  00 NOP, 01 ACCUM, 10 HOLD, 11 DIV
- in_valid  in  1  in_data valid (ofifo read data)
- in_data  in  col*bw_psum  signed psums, element i at [i*bw_psum +: bw_psum]
- int_fifo_full  in  1  inter-core FIFO full
- sum_out  out  bw_sum  local abs sum to partner
- sum_out_wr  out  1  push strobe
- sum_in  in  bw_sum  partner sum (FWFT head)
- sum_in_valid  in  1  partner FIFO non-empty
- sum_in_rd  out  1  pop strobe
- out_data  out  col*(FRAC+1)  normalized unsigned results
- out_valid  out  1  one-cycle result strobe
- sfp_ready  out  1  high in S_IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset mid-operation discards all work.
- Reset values:
  - state=S_IDLE.
  - in_reg, local_sum, total, out_data, element/bit counters all 0.
  - out_valid=0, sum_out_wr=0, sum_in_rd=0, sfp_ready=1.
- States:
  - S_IDLE: sfp_op==ACCUM && in_valid → latch in_data, go S_SUM. Any other op/valid combination is ignored.
  - S_SUM: local_sum <= sum of |in_reg_i|, all unsigned. |most-negative| = 2^(bw_psum-1), which fits unsigned bw_psum. Go S_PUSH.
  - S_PUSH: sum_out = local_sum. sum_out_wr = ~int_fifo_full (combinational). Leave for S_WAIT on the cycle the push occurs; otherwise stall.
  - S_WAIT: sum_in_rd = sum_in_valid (combinational, FWFT pop). Same cycle: total <= local_sum + sum_in (bw_sum+1 bits), go S_ARMED.
  - S_ARMED: hold until sfp_op==DIV (HOLD/NOP wait). Then:
    - total==0 → out_data <= 0, go S_DONE.
    - else go S_DIV.
  - S_DIV: sequential restoring divider, one element at a time, element 0 first, FRAC+1 cycles per element.
    - Init r=|in_reg_i|.
    - Each step: q = q<<1 | (r>=total); if r>=total then r -= total; r <<= 1.
    - Remainder register is bw_sum+2 bits.
    - After FRAC+1 steps, write q to out_data element i.
    - After element col-1, go S_DONE. Total col*(FRAC+1) cycles.
  - S_DONE: out_valid=1 for exactly one cycle, go S_IDLE.
- out_data holds its value until the next DIV completes.
- Result range: 0..2^FRAC (2^FRAC only when |psum_i|==total).
- Latencies: ACCUM accept edge T → sum_out_wr high in cycle T+2 if not full.
- Opcodes arriving in a state that does not consume them are ignored, not queued.
- sfp_ready is low in every state except S_IDLE.

Test Plan:
- Basic normalize: all 8 psums=16, partner sum_in=128, DIV → sum_out=128, total=256, every out element=16; out_valid 1 cycle after 72 DIV cycles.
- Signed inputs: psums {-16,16,-16,16,-16,16,-16,16}, partner 128 → identical result to the basic case; sum_out=128.
- Saturation edge: element0=100, others 0, partner 0 → total=100, out element0=256 (9'h100), others 0. Separately, psum=-2^23 alone → sum_out=2^23.
- Zero total: all psums 0, partner 0, DIV → out_data all 0, no S_DIV cycles, out_valid on the cycle after DIV is accepted.
- Backpressure/handshake:
  - int_fifo_full held 5 cycles → sum_out_wr stays 0 and state holds, then pushes exactly once.
  - sum_in_valid delayed → no pop and sfp_ready stays 0 until it rises.
  - DIV issued before the partner sum arrives is ignored.
- Reset mid-divide: assert reset during cycle 30 of S_DIV → next cycle all outputs are at reset values, sfp_ready=1. A new ACCUM then completes correctly.
